elevator_req_sched: RTL and testbench

//  Upstream request scheduler for the 2-bit elevator FSM.
//  - Latches floor call buttons into a pending mask.
//  - Picks the next target floor by LOOK ordering (keep direction while calls remain ahead).
//  - Drives the FSM's floor input and consumes its current-floor output (cf).
//  - Manages door dwell on arrival.

---
 rtl/elevator_req_sched_if.sv | 18 +
 rtl/elevator_req_sched.sv | 105 ++++++++++
 tb/tb_elevator_req_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/elevator_req_sched_if.sv
// elevator_req_sched_if: call buttons, car position and scheduler outputs (emerg only with SCHED_EMERG_EN)
interface elevator_req_sched_if;
  logic [3:0] req_btn;
  logic [1:0] cf;
  logic [1:0] floor;
  logic       tgt_valid;
  logic       dir_up;
  logic       door_open;
  logic [3:0] pending;
`ifdef SCHED_EMERG_EN
  logic       emerg;
  modport master (output req_btn, cf, emerg, input floor, tgt_valid, dir_up, door_open, pending);
  modport slave (input req_btn, cf, emerg, output floor, tgt_valid, dir_up, door_open, pending);
`else
  modport master (output req_btn, cf, input floor, tgt_valid, dir_up, door_open, pending);
  modport slave (input req_btn, cf, output floor, tgt_valid, dir_up, door_open, pending);
`endif
endinterface

// File: rtl/elevator_req_sched.sv
// elevator_req_sched: LOOK-ordered call scheduler with door dwell for a 4-floor car
// SCHED_EMERG_EN adds an emergency recall to floor 0 with the door held open
module elevator_req_sched #(
  parameter int NUM_FLOORS   = 4,
  parameter int DWELL_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  elevator_req_sched_if.slave sched
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_MOVE  = 2'b01;
  localparam logic [1:0] S_DWELL = 2'b10;
  localparam int CW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DWELL_CYCLES - 1);
  logic [1:0]    r_state, w_state;
  logic [3:0]    r_pending, w_pending;
  logic [1:0]    r_floor, w_floor;
  logic          r_dir_up, w_dir_up;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    w_clr, w_cf_oh;
  logic          w_up_hit, w_dn_hit;
  logic [1:0]    w_up_f, w_dn_f;
  assign w_cf_oh = 4'b0001 << sched.cf;
  // nearest pending floor strictly above and strictly below the car
  always_comb begin
    w_up_hit = 1'b0;
    w_up_f   = '0;
    w_dn_hit = 1'b0;
    w_dn_f   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (r_pending[i] && 3'(i) > {1'b0, sched.cf}) begin
        w_up_hit = 1'b1;
        w_up_f   = 2'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (r_pending[i] && 3'(i) < {1'b0, sched.cf}) begin
        w_dn_hit = 1'b1;
        w_dn_f   = 2'(i);
      end
  end
  always_comb begin
    w_state  = r_state;
    w_floor  = r_floor;
    w_dir_up = r_dir_up;
    w_cnt    = r_cnt;
    w_clr    = '0;
    if (r_state == S_IDLE) begin
      if (r_pending[sched.cf]) begin
        w_state = S_DWELL;
        w_cnt   = LOAD;
        w_clr   = w_cf_oh;
      end else if (|r_pending) begin
        w_state  = S_MOVE;
        w_floor  = r_dir_up ? (w_up_hit ? w_up_f : w_dn_f) : (w_dn_hit ? w_dn_f : w_up_f);
        w_dir_up = r_dir_up ? w_up_hit : !w_dn_hit;
      end
    end else if (r_state == S_MOVE) begin
      if (sched.cf == r_floor) begin
        w_state = S_DWELL;
        w_cnt   = LOAD;
        w_clr   = w_cf_oh;
      end else if (r_dir_up && w_up_hit && w_up_f < r_floor) begin
        w_floor = w_up_f;
      end else if (!r_dir_up && w_dn_hit && w_dn_f > r_floor) begin
        w_floor = w_dn_f;
      end
    end else begin
      w_clr   = w_cf_oh;
      w_state = r_cnt == '0 ? S_IDLE : S_DWELL;
      w_cnt   = r_cnt == '0 ? '0 : r_cnt - 1'b1;
    end
    w_pending = (r_pending | sched.req_btn) & ~w_clr;
`ifdef SCHED_EMERG_EN
    // recall to floor 0; the counter stays frozen while the door is held there
    if (sched.emerg) begin
      w_pending = '0;
      w_floor   = 2'b00;
      w_dir_up  = 1'b0;
      w_state   = sched.cf == 2'b00 ? S_DWELL : S_MOVE;
      w_cnt     = (r_state == S_DWELL && sched.cf == 2'b00) ? r_cnt : LOAD;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_floor   <= 2'b00;
      r_dir_up  <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_pending <= w_pending;
      r_floor   <= w_floor;
      r_dir_up  <= w_dir_up;
      r_cnt     <= w_cnt;
    end
  end
  assign sched.floor     = r_floor;
  assign sched.tgt_valid = r_state == S_MOVE;
  assign sched.door_open = r_state == S_DWELL;
  assign sched.dir_up    = r_dir_up;
  assign sched.pending   = r_pending;
endmodule

// File: tb/tb_elevator_req_sched.sv
// tb_elevator_req_sched: random calls against a floor-search reference model, queued expectations
module tb_elevator_req_sched;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst;
  elevator_req_sched_if bus ();
  elevator_req_sched #(.NUM_FLOORS(4), .DWELL_CYCLES(DW)) dut (.clk(clk), .rst(rst), .sched(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  // reference car: 0 idle, 1 travelling, 2 door open
  int m_mode, m_floor, m_left, cf_v, tick;
  bit m_up;
  bit [3:0] m_pend;
  function automatic int nearest(input int from, input bit up);
    for (int d = 1; d < 4; d++) begin
      int f;
      f = up ? from + d : from - d;
      if (f >= 0 && f < 4 && m_pend[f]) return f;
    end
    return -1;
  endfunction
  task automatic model_step(input bit r, input bit [3:0] req, input int cf);
    int clear, t;
    clear = -1;
    if (r) begin
      m_mode = 0; m_pend = 0; m_floor = 0; m_up = 1; m_left = 0;
      return;
    end
    if (m_mode == 0) begin
      if (m_pend[cf]) begin
        m_mode = 2; m_left = DW; clear = cf;
      end else if (m_pend != 0) begin
        t = nearest(cf, m_up);
        if (t < 0) begin
          m_up = !m_up;
          t = nearest(cf, m_up);
        end
        m_floor = t; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (cf == m_floor) begin
        m_mode = 2; m_left = DW; clear = cf;
      end else begin
        t = nearest(cf, m_up);
        if (t >= 0 && (m_up ? t < m_floor : t > m_floor)) m_floor = t;
      end
    end else begin
      clear = cf;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    m_pend = m_pend | req;
    if (clear >= 0) m_pend[clear] = 1'b0;
  endtask
  task automatic cycle(input bit r, input bit [3:0] req);
    @(negedge clk);
    if (m_mode == 1 && cf_v != m_floor) begin
      tick++;
      if (tick >= 3) begin
        tick = 0;
        cf_v = m_floor > cf_v ? cf_v + 1 : cf_v - 1;
      end
    end
    rst = r;
    bus.req_btn = req;
    bus.cf = 2'(cf_v);
    model_step(r, req, cf_v);
    exp_q.push_back({2'(m_floor), m_mode == 1, m_up, m_mode == 2, m_pend});
  endtask
  initial begin
    logic [8:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.floor, bus.tgt_valid, bus.dir_up, bus.door_open, bus.pending};
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got floor=%0d tv=%b up=%b door=%b pend=%b, expected floor=%0d tv=%b up=%b door=%b pend=%b",
                   $time, g[8:7], g[6], g[5], g[4], g[3:0], e[8:7], e[6], e[5], e[4], e[3:0]);
        end
      end
    end
  end
  initial begin
    cf_v = 0; tick = 0;
    m_mode = 0; m_pend = 0; m_floor = 0; m_up = 1; m_left = 0;
`ifdef SCHED_EMERG_EN
    bus.emerg = 1'b0;
`endif
    cycle(1, 4'b0000);
    cycle(1, 4'b0000);
    cycle(0, 4'b1000);
    repeat (25) cycle(0, 4'b0000);
    cycle(0, 4'(1 << cf_v));
    cycle(0, 4'b0000);
    cycle(0, 4'(1 << cf_v));
    repeat (8) cycle(0, 4'b0000);
    cycle(0, 4'(1 << ((cf_v + 2) % 4)));
    repeat (2) cycle(0, 4'b0000);
    cycle(1, 4'b0000);
    repeat (3) cycle(0, 4'b0000);
    for (int n = 0; n < 4000; n++)
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'b0000);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
